// File: rtl/gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gate_arbiter
// Purpose  : Shares one parking-lot barrier between the entry and exit
//            requesters. Grants one direction at a time, refuses entry when
//            the lot is full and exit when it is empty, and alternates on
//            contention. Emits inc/dec pulses only on an actual passage.
// Revision : 1.0 - initial release
// ============================================================================
module gate_arbiter #(
  parameter int CAP     = 7,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 16,
  parameter int HOLD    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             passed,
  input  logic [CNT_W-1:0] count,
  output logic             gate_open,
  output logic             grant_in,
  output logic             grant_out,
  output logic             inc,
  output logic             dec,
  output logic             timeout,
  output logic             full,
  output logic             empty
);

  // One timer serves both the open phase and the closed hold phase
  localparam int TMAX = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD - 1);
  localparam logic [CNT_W:0]   CAP_V     = (CNT_W + 1)'(CAP);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OPEN_IN  = 2'd1,
    S_OPEN_OUT = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            last_in_q, last_in_d;   // 1: entry was served last
  logic            gate_open_q, gate_open_d;
  logic            grant_in_q, grant_in_d;
  logic            grant_out_q, grant_out_d;
  logic            inc_q, inc_d;
  logic            dec_q, dec_d;
  logic            timeout_q, timeout_d;

  logic            entry_ok;
  logic            exit_ok;

  // Occupancy status follows the counter with no latency
  assign full     = ({1'b0, count} >= CAP_V);
  assign empty    = (count == '0);
  assign entry_ok = req_in & ~full;
  assign exit_ok  = req_out & ~empty;

  // Next-state, timer, priority and registered-output computation
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    last_in_d = last_in_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        // On contention the direction not served last wins
        if (entry_ok && (!exit_ok || !last_in_q)) begin
          state_d   = S_OPEN_IN;
          last_in_d = 1'b1;
        end else if (exit_ok) begin
          state_d   = S_OPEN_OUT;
          last_in_d = 1'b0;
        end
      end
      S_OPEN_IN, S_OPEN_OUT: begin
        // Passage takes precedence over a coincident expiry
        if (passed) begin
          state_d = S_HOLD;
          timer_d = '0;
          inc_d   = (state_q == S_OPEN_IN);
          dec_d   = (state_q == S_OPEN_OUT);
        end else if (timer_q == TO_LAST) begin
          state_d   = S_HOLD;
          timer_d   = '0;
          timeout_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    gate_open_d = (state_d == S_OPEN_IN) || (state_d == S_OPEN_OUT);
    grant_in_d  = (state_d == S_OPEN_IN);
    grant_out_d = (state_d == S_OPEN_OUT);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      last_in_q   <= 1'b0;
      gate_open_q <= 1'b0;
      grant_in_q  <= 1'b0;
      grant_out_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_in_q   <= last_in_d;
      gate_open_q <= gate_open_d;
      grant_in_q  <= grant_in_d;
      grant_out_q <= grant_out_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gate_open = gate_open_q;
  assign grant_in  = grant_in_q;
  assign grant_out = grant_out_q;
  assign inc       = inc_q;
  assign dec       = dec_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: doc/gate_arbiter.md
# gate_arbiter

Single-lane barrier controller that shares one physical gate between the entry and exit vehicle requesters of the parking lot. It sits between the debounced sensor/FSM logic and the 3-bit up/down occupancy counter. It grants the gate to one direction at a time, refusing entry when the lot is full and exit when it is empty, and alternates priority on contention. It emits single-cycle increment/decrement pulses to the counter only when a vehicle actually clears the gate.

## Interface
- CAP, 7: lot capacity; entry is refused when count >= CAP
- CNT_W, 3: occupancy count width
- TIMEOUT, 16: maximum cycles the gate stays open waiting for a vehicle to pass (>= 2)
- HOLD, 2: cycles the gate is held closed after every open phase, before new arbitration (>= 1)

- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- req_in  in  1  level: vehicle waiting at entry (debounced)
- req_out  in  1  level: vehicle waiting at exit (debounced)
- passed  in  1  one-cycle pulse: vehicle has fully cleared the gate
- count  in  CNT_W  current occupancy from the counter
- gate_open  out  1  barrier raise command (registered)
- grant_in  out  1  gate currently owned by entry (registered)
- grant_out  out  1  gate currently owned by exit (registered); never both high together
- inc  out  1  one-cycle pulse to counter: vehicle entered
- dec  out  1  one-cycle pulse to counter: vehicle left
- timeout  out  1  one-cycle pulse: open phase expired without passage
- full  out  1  combinational, count >= CAP
- empty  out  1  combinational, count == 0

## Operation
- States: IDLE, OPEN_IN, OPEN_OUT, HOLD.
- Eligibility, evaluated in IDLE only: entry_ok = req_in & ~full; exit_ok = req_out & ~empty.
- IDLE: entry_ok only -> OPEN_IN; exit_ok only -> OPEN_OUT; both -> the direction not served last; neither -> stay.
- last_served flag is updated on every grant; its reset value is "exit", so entry wins the first contention after reset.
- OPEN_IN/OPEN_OUT: gate_open=1, matching grant=1, and the timer counts from 0 each cycle.
  - passed=1 -> HOLD, with a one-cycle inc (OPEN_IN) or dec (OPEN_OUT).
  - Otherwise, timer == TIMEOUT-1 -> HOLD, with a one-cycle timeout and no inc/dec.
  - passed in the same cycle as timer expiry: passage wins (inc/dec, no timeout).
- HOLD: gate_open=0, grants=0, counts HOLD cycles, then IDLE.
- passed is ignored in IDLE and HOLD.
- Eligibility is checked only at grant time. A count change during OPEN does not abort the phase.
- inc and dec are never asserted together. At most one pulse is issued per open phase.
- Timer width is clog2(max(TIMEOUT,HOLD)+1); it is reused for HOLD and cleared on every state entry.
- Reset, including mid-operation: state=IDLE, timer=0, last_served=exit. gate_open, grant_in, grant_out, inc, dec and timeout are all 0 on the cycle after the reset edge. Any in-flight passage is dropped with no inc/dec.

## Timing
- IDLE with eligible request at edge N: grant and gate_open high after edge N (latency 1 cycle).
- passed high at edge M in OPEN_x: inc/dec high for exactly the cycle after edge M; gate_open low in that same cycle.
- Gate is open at most TIMEOUT cycles per grant; timeout pulse coincides with the first HOLD cycle.
- HOLD occupies exactly HOLD cycles. The earliest next grant is visible HOLD+1 cycles after the inc/dec/timeout cycle.
- The counter sees inc/dec one cycle after assertion, so the next IDLE eligibility check uses the updated count whenever HOLD >= 1.
- full and empty follow count with zero latency.

## Test plan
- Reset, count=0, req_in=1 -> cycle after release: grant_in=1, gate_open=1. passed pulse at cycle 5 -> inc=1 for one cycle, then HOLD 2 cycles, then IDLE.
- count=7, req_in=1, req_out=0 -> no grant for 50 cycles, full=1. Set req_out=1 -> grant_out next cycle; passed -> dec pulse.
- count=3, req_in=req_out=1 held, passed every open phase -> grants alternate in, out, in, out, with entry first after reset. Exactly one inc or dec per phase.
- count=2, req_out=1, no passed -> gate_open high exactly 16 cycles, timeout pulse, no dec, 2 HOLD cycles, then re-grant to exit.
- passed asserted on the 16th open cycle -> dec=1, timeout=0.
- reset asserted during OPEN_IN, same cycle as passed -> next cycle all outputs 0, inc stays 0, state IDLE. passed pulses while in IDLE produce no inc/dec.
